// File: rtl/car_speed_ctrl_if.sv
// Game-control bundle between the car game logic and the speed scheduler:
// start/pause/crash requests in, tick strobe and status out.
interface car_speed_ctrl_if;
    logic       start;
    logic       pause;
    logic       crash;
    logic       move_tick;
    logic [1:0] level;
    logic [2:0] speed_sel;
    logic       running;
    logic       game_over;

    modport master (
        output start,
        output pause,
        output crash,
        input  move_tick,
        input  level,
        input  speed_sel,
        input  running,
        input  game_over
    );

    modport slave (
        input  start,
        input  pause,
        input  crash,
        output move_tick,
        output level,
        output speed_sel,
        output running,
        output game_over
    );
endinterface

// File: rtl/car_speed_ctrl.sv
// Speed scheduler for the car game: divides CLOCK_50 into a move_tick strobe
// whose period shortens 1/2 s -> 1/4 s -> 1/8 s and sequences IDLE/RUN/PAUSED/OVER.
module car_speed_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICKS_PER_LEVEL = 16
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    car_speed_ctrl_if.slave   bus
);

    localparam int P0     = CLK_HZ / 2;
    localparam int P1     = CLK_HZ / 4;
    localparam int P2     = CLK_HZ / 8;
    localparam int CNT_W  = $clog2(P0);
    localparam int TCNT_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    localparam logic [CNT_W-1:0]  LAST0     = CNT_W'(P0 - 1);
    localparam logic [CNT_W-1:0]  LAST1     = CNT_W'(P1 - 1);
    localparam logic [CNT_W-1:0]  LAST2     = CNT_W'(P2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_LEVEL - 1);
    localparam logic [1:0]        LVL_MAX   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic [1:0]          level, level_n;
    logic                tick, tick_n;

    function automatic logic [CNT_W-1:0] period_last(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return LAST0;
            2'd1:    return LAST1;
            default: return LAST2;
        endcase
    endfunction

    function automatic logic [2:0] level_onehot(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            tcnt  <= '0;
            level <= 2'd0;
            tick  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tcnt  <= tcnt_n;
            level <= level_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        level_n = level;
        tick_n  = 1'b0;

        case (state)
            IDLE, OVER: begin
                // OVER keeps level on display until the next game starts
                if (bus.start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    tcnt_n  = '0;
                    level_n = 2'd0;
                end
            end

            RUN: begin
                if (bus.crash) begin
                    state_n = OVER;
                end else if (bus.pause) begin
                    // cnt may sit at P-1 here; the tick then fires on resume
                    state_n = PAUSED;
                end else if (cnt == period_last(level)) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    if (tcnt == TCNT_LAST) begin
                        tcnt_n = '0;
                        if (level < LVL_MAX)
                            level_n = level + 2'd1;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            PAUSED: begin
                if (bus.crash)
                    state_n = OVER;
                else if (!bus.pause)
                    state_n = RUN;
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.move_tick = tick;
    assign bus.level     = level;
    assign bus.speed_sel = level_onehot(level);
    assign bus.running   = (state == RUN);
    assign bus.game_over = (state == OVER);

endmodule

// File: tb/tb_car_speed_ctrl.sv
// Bench for car_speed_ctrl: directed scenarios plus random play against a
// cycle-level reference model of the game rules.
module tb_car_speed_ctrl;

    localparam int CLK_HZ = 16;
    localparam int TPL    = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_OVER   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    car_speed_ctrl_if bus();

    car_speed_ctrl #(
        .CLK_HZ(CLK_HZ),
        .TICKS_PER_LEVEL(TPL)
    ) dut (
        .CLOCK_50(clk),
        .Reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    // reference model: elapsed cycles in the current period, ticks issued at this level
    int m_mode  = M_IDLE;
    int m_phase = 0;
    int m_tix   = 0;
    int m_lvl   = 0;
    bit m_tick  = 1'b0;

    function automatic int period_of(input int lvl);
        return CLK_HZ / (2 << lvl);
    endfunction

    task automatic model_step();
        m_tick = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_phase = 0; m_tix = 0; m_lvl = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_OVER: if (bus.start) begin
                    m_mode = M_RUN; m_phase = 0; m_tix = 0; m_lvl = 0;
                end
                M_RUN: begin
                    if (bus.crash) m_mode = M_OVER;
                    else if (bus.pause) m_mode = M_PAUSED;
                    else begin
                        m_phase = m_phase + 1;
                        if (m_phase == period_of(m_lvl)) begin
                            m_phase = 0;
                            m_tick  = 1'b1;
                            m_tix   = m_tix + 1;
                            if (m_tix == TPL) begin
                                m_tix = 0;
                                if (m_lvl < 2) m_lvl = m_lvl + 1;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.crash) m_mode = M_OVER;
                    else if (!bus.pause) m_mode = M_RUN;
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.crash = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.move_tick !== 1'b0) $display("FAIL reset_tick got %0b want 0", bus.move_tick); else passes++;
        checks++; if (bus.level !== 2'd0) $display("FAIL reset_level got %0d want 0", bus.level); else passes++;
        checks++; if (bus.speed_sel !== 3'b100) $display("FAIL reset_speed_sel got %b want 100", bus.speed_sel); else passes++;
        checks++; if (bus.running !== 1'b0) $display("FAIL reset_running got %0b want 0", bus.running); else passes++;
        checks++; if (bus.game_over !== 1'b0) $display("FAIL reset_game_over got %0b want 0", bus.game_over); else passes++;
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (bus.move_tick !== 1'b0 || bus.level !== 2'd0 || bus.speed_sel !== 3'b100 || bus.running !== 1'b0)
                $display("FAIL idle cyc%0d got tick=%0b lvl=%0d sel=%b run=%0b want 0/0/100/0",
                         i, bus.move_tick, bus.level, bus.speed_sel, bus.running);
            else passes++;
        end
    endtask

    task automatic test_levels();
        logic       exp_tick;
        logic [1:0] exp_lvl;
        do_reset();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        checks++; if (bus.running !== 1'b1) $display("FAIL start_running got %0b want 1", bus.running); else passes++;
        for (int e = 1; e <= 50; e++) begin
            cycle();
            exp_tick = (e == 8 || e == 16 || e == 24 || e == 28 || e == 32 || e == 36 || (e > 36 && e % 2 == 0));
            exp_lvl  = (e < 24) ? 2'd0 : (e < 36) ? 2'd1 : 2'd2;
            checks++;
            if (bus.move_tick !== exp_tick) $display("FAIL levels_tick edge%0d got %0b want %0b", e, bus.move_tick, exp_tick);
            else passes++;
            checks++;
            if (bus.level !== exp_lvl || bus.speed_sel !== (3'b100 >> exp_lvl))
                $display("FAIL levels_lvl edge%0d got %0d/%b want %0d/%b", e, bus.level, bus.speed_sel, exp_lvl, 3'b100 >> exp_lvl);
            else passes++;
        end
    endtask

    task automatic test_pause();
        do_reset();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (bus.move_tick !== 1'b0 || bus.running !== 1'b0)
                $display("FAIL pause_hold cyc%0d got tick=%0b run=%0b want 0/0", i, bus.move_tick, bus.running);
            else passes++;
        end
        bus.pause = 1'b0;
        cycle();
        checks++; if (bus.running !== 1'b1) $display("FAIL pause_resume_running got %0b want 1", bus.running); else passes++;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            checks++;
            if (bus.move_tick !== (i == 3)) $display("FAIL pause_resume_tick edge+%0d got %0b want %0b", i, bus.move_tick, (i == 3));
            else passes++;
        end
    endtask

    task automatic test_crash_at_wrap();
        do_reset();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        bus.crash = 1'b1;
        cycle();
        bus.crash = 1'b0;
        checks++; if (bus.move_tick !== 1'b0) $display("FAIL crash_wrap_tick got %0b want 0", bus.move_tick); else passes++;
        checks++; if (bus.game_over !== 1'b1 || bus.running !== 1'b0)
            $display("FAIL crash_wrap_state got over=%0b run=%0b want 1/0", bus.game_over, bus.running); else passes++;
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (bus.move_tick !== 1'b0 || bus.game_over !== 1'b1) $display("FAIL crash_over_hold got tick=%0b over=%0b want 0/1", bus.move_tick, bus.game_over); else passes++;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        checks++; if (bus.level !== 2'd0 || bus.running !== 1'b1) $display("FAIL restart got lvl=%0d run=%0b want 0/1", bus.level, bus.running); else passes++;
        for (int e = 1; e <= 8; e++) begin
            cycle();
            checks++;
            if (bus.move_tick !== (e == 8)) $display("FAIL restart_tick edge%0d got %0b want %0b", e, bus.move_tick, (e == 8));
            else passes++;
        end
    endtask

    task automatic test_crash_in_pause();
        do_reset();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 26; i++) cycle();
        bus.pause = 1'b1;
        cycle();
        cycle();
        bus.crash = 1'b1;
        cycle();
        bus.crash = 1'b0;
        checks++; if (bus.game_over !== 1'b1 || bus.running !== 1'b0) $display("FAIL pause_crash got over=%0b run=%0b want 1/0", bus.game_over, bus.running); else passes++;
        checks++; if (bus.level !== 2'd1) $display("FAIL pause_crash_level got %0d want 1", bus.level); else passes++;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (bus.game_over !== 1'b1 || bus.running !== 1'b0 || bus.move_tick !== 1'b0 || bus.level !== 2'd1)
                $display("FAIL over_pause cyc%0d got over=%0b run=%0b tick=%0b lvl=%0d want 1/0/0/1",
                         i, bus.game_over, bus.running, bus.move_tick, bus.level);
            else passes++;
        end
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_at_level2();
        do_reset();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 41; i++) cycle();
        checks++; if (bus.level !== 2'd2) $display("FAIL pre_reset_level got %0d want 2", bus.level); else passes++;
        reset = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.move_tick !== 1'b0 || bus.level !== 2'd0 || bus.speed_sel !== 3'b100 ||
                bus.running !== 1'b0 || bus.game_over !== 1'b0)
                $display("FAIL reset_l2 cyc%0d got tick=%0b lvl=%0d sel=%b run=%0b over=%0b want 0/0/100/0/0",
                         i, bus.move_tick, bus.level, bus.speed_sel, bus.running, bus.game_over);
            else passes++;
        end
        reset = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] exp_sel;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(299) == 0);
            bus.start = ($urandom_range(3) == 0);
            bus.crash = ($urandom_range(99) == 0);
            if ($urandom_range(7) == 0) bus.pause = ($urandom_range(2) == 0);
            cycle();
            exp_sel = 3'b100 >> m_lvl;
            checks++;
            if (bus.move_tick !== m_tick || bus.level !== 2'(m_lvl) || bus.speed_sel !== exp_sel ||
                bus.running !== (m_mode == M_RUN) || bus.game_over !== (m_mode == M_OVER))
                $display("FAIL random cyc%0d got tick=%0b lvl=%0d sel=%b run=%0b over=%0b want %0b/%0d/%b/%0b/%0b",
                         i, bus.move_tick, bus.level, bus.speed_sel, bus.running, bus.game_over,
                         m_tick, m_lvl, exp_sel, (m_mode == M_RUN), (m_mode == M_OVER));
            else passes++;
        end
        reset = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.crash = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.crash = 1'b0;
        #1;
        test_reset();
        test_idle();
        test_levels();
        test_pause();
        test_crash_at_wrap();
        test_crash_in_pause();
        test_reset_at_level2();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
